// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default field widths, the NOP opcode and the
// EX/MEM payload layout used by neighbouring stages.
package pipe_pkg;

    localparam int unsigned OPCODE_W_DEF   = 5;
    localparam int unsigned RD_W_DEF       = 9;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned NOP_OPCODE_DEF = 0;

    typedef struct packed {
        logic [OPCODE_W_DEF-1:0] opcode;
        logic [RD_W_DEF-1:0]     rd;
        logic [DATA_W_DEF-1:0]   branch_result;
        logic [DATA_W_DEF-1:0]   alu_result;
    } exmem_payload_t;

    localparam int unsigned EXMEM_PAYLOAD_W = $bits(exmem_payload_t);

    // Bubble value the stage shows when it is empty after reset or flush.
    function automatic exmem_payload_t nop_payload();
        exmem_payload_t p;
        p        = '0;
        p.opcode = OPCODE_W_DEF'(NOP_OPCODE_DEF);
        return p;
    endfunction

endpackage

// File: rtl/exmem_skid_reg_if.sv
// EX/MEM stage bus: upstream handshake and payload, downstream handshake and
// payload, flush and the stall counter observation port.
interface exmem_skid_reg_if #(
    parameter int unsigned OPCODE_W = pipe_pkg::OPCODE_W_DEF,
    parameter int unsigned RD_W     = pipe_pkg::RD_W_DEF,
    parameter int unsigned DATA_W   = pipe_pkg::DATA_W_DEF,
    parameter int unsigned CNT_W    = pipe_pkg::CNT_W_DEF
);

    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] OpCode;
    logic [RD_W-1:0]     RdOut;
    logic [DATA_W-1:0]   BranchResult;
    logic [DATA_W-1:0]   AluResult;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [OPCODE_W-1:0] OpCodeOut;
    logic [RD_W-1:0]     RdOutOut;
    logic [DATA_W-1:0]   BranchResultOut;
    logic [DATA_W-1:0]   AluResultOut;
    logic [CNT_W-1:0]    stall_cnt;

    // Surrounding pipeline (EX producer plus MEM consumer).
    modport master (
        output in_valid, OpCode, RdOut, BranchResult, AluResult, flush, out_ready,
        input  in_ready, out_valid, OpCodeOut, RdOutOut, BranchResultOut,
               AluResultOut, stall_cnt
    );

    // The pipeline register itself.
    modport slave (
        input  in_valid, OpCode, RdOut, BranchResult, AluResult, flush, out_ready,
        output in_ready, out_valid, OpCodeOut, RdOutOut, BranchResultOut,
               AluResultOut, stall_cnt
    );

endinterface

// File: rtl/exmem_skid_reg_skid_buffer.sv
// Generic two-entry valid/ready buffer: a main entry drives the outputs and a
// skid entry absorbs the one extra transfer accepted while the consumer stalls.
module skid_buffer #(
    parameter int unsigned W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept_c;
    logic         drain_c;

    assign accept_c = in_valid & in_ready;
    assign drain_c  = out_valid & out_ready;

    // in_ready is kept as its own flop so it never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= RST_VAL;
            skid_valid <= 1'b0;
            skid_data  <= RST_VAL;
            in_ready   <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_data   <= RST_VAL;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (skid_valid && drain_c) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if ((!out_valid || drain_c) && accept_c) begin
            out_valid  <= 1'b1;
            out_data   <= in_data;
        end else if (out_valid && accept_c) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            in_ready   <= 1'b0;
        end else if (drain_c) begin
            // Payload deliberately held so MEM can still observe the last instruction.
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register: packs the instruction fields into a skid buffer
// and counts cycles in which MEM holds off a valid instruction.
module exmem_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned         OPCODE_W   = OPCODE_W_DEF,
    parameter int unsigned         RD_W       = RD_W_DEF,
    parameter int unsigned         DATA_W     = DATA_W_DEF,
    parameter logic [OPCODE_W-1:0] NOP_OPCODE = OPCODE_W'(NOP_OPCODE_DEF),
    parameter int unsigned         CNT_W      = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst,
    exmem_skid_reg_if.slave  bus
);

    localparam int unsigned  TAIL_W  = RD_W + 2 * DATA_W;
    localparam int unsigned  W       = OPCODE_W + TAIL_W;
    localparam logic [W-1:0] RST_VAL = {NOP_OPCODE, {TAIL_W{1'b0}}};

    logic [W-1:0]     in_data;
    logic [W-1:0]     out_data;
    logic             in_ready;
    logic             out_valid;
    logic [CNT_W-1:0] stall_cnt;

    assign in_data = {bus.OpCode, bus.RdOut, bus.BranchResult, bus.AluResult};

    skid_buffer #(
        .W       (W),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign {bus.OpCodeOut, bus.RdOutOut, bus.BranchResultOut, bus.AluResultOut} = out_data;

    // Saturating stall counter; flush does not clear it, only reset does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!bus.flush && out_valid && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt;

endmodule
